// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding and the fractional baud increment.
// The increment is shared with the TX baud generator so both ends agree on the bit rate.
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT
  } rx_state_e;

  // Accumulator step giving Baud*Oversampling ticks/s; kept within 32-bit arithmetic.
  function automatic int unsigned baud_inc(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned oversampling,
                                           input int unsigned acc_width);
    return (((baud * oversampling) << (acc_width - 7)) + (clk_hz >> 8)) / (clk_hz >> 7);
  endfunction

endpackage

// File: rtl/async_receiver_if.sv
// Serial line plus receiver result signals; slave = receiver, master = line driver / byte consumer.
`timescale 1ns/1ps
interface async_receiver_if;
  logic       RxD;
  logic [7:0] RxD_data;
  logic       RxD_data_ready;
  logic       RxD_framing_error;
  logic       RxD_idle;
  logic       RxD_endofpacket;

  modport master (
    output RxD,
    input  RxD_data, RxD_data_ready, RxD_framing_error, RxD_idle, RxD_endofpacket
  );

  modport slave (
    input  RxD,
    output RxD_data, RxD_data_ready, RxD_framing_error, RxD_idle, RxD_endofpacket
  );
endinterface

// File: rtl/baud_tick_gen.sv
// Fractional accumulator producing one-clk ticks at Baud*Oversampling; the carry out is the tick.
// Free-running, no backpressure; tick comes from a register so it is glitch-free.
`timescale 1ns/1ps
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned ClkFrequency = 25000000,
  parameter int unsigned Baud         = 115200,
  parameter int unsigned Oversampling = 16,
  parameter int unsigned AccWidth     = 17
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned Inc = baud_inc(ClkFrequency, Baud, Oversampling, AccWidth);
  localparam logic [AccWidth:0] IncW = (AccWidth + 1)'(Inc);

  logic [AccWidth:0] acc_q, acc_d;

  assign acc_d = {1'b0, acc_q[AccWidth-1:0]} + IncW;
  assign tick  = acc_q[AccWidth];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/async_receiver.sv
// 8N1 UART receiver: 2-flop sync, 3-tap majority filter, oversampled FSM, idle/end-of-packet detect.
// Byte strobe lands one clk after the stop-bit mid-sample tick; no backpressure, consumer must take it.
`timescale 1ns/1ps
module async_receiver
  import uart_pkg::*;
#(
  parameter int unsigned ClkFrequency = 25000000,
  parameter int unsigned Baud         = 115200,
  parameter int unsigned Oversampling = 16,
  parameter int unsigned AccWidth     = 17
) (
  input  logic            clk,
  input  logic            rst,
  async_receiver_if.slave bus
);

  localparam int CntW = $clog2(Oversampling);
  localparam int GapW = $clog2(10 * Oversampling + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(Oversampling - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(Oversampling / 2 - 1);
  localparam logic [GapW-1:0] GapMax  = GapW'(10 * Oversampling);

  logic            tick;
  logic [1:0]      sync_q;
  logic [2:0]      filt_q;
  logic            bit_f;
  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bitn_q, bitn_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      data_q, data_d;
  logic            rdy_q, rdy_d;
  logic            ferr_q, ferr_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic            idle_q, idle_d;
  logic            idle_prev_q;
  logic            got_byte_q, got_byte_d;
  logic            eop;

  baud_tick_gen #(
    .ClkFrequency (ClkFrequency),
    .Baud         (Baud),
    .Oversampling (Oversampling),
    .AccWidth     (AccWidth)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign bit_f = (filt_q[0] & filt_q[1]) | (filt_q[0] & filt_q[2]) | (filt_q[1] & filt_q[2]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bitn_d  = bitn_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    rdy_d   = 1'b0;
    ferr_d  = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (!bit_f) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: begin
          if (cnt_q == CntHalf) begin
            cnt_d  = '0;
            bitn_d = '0;
            state_d = bit_f ? IDLE : DATA;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        DATA: begin
          if (cnt_q == CntLast) begin
            cnt_d   = '0;
            shreg_d = {bit_f, shreg_q[7:1]};
            bitn_d  = bitn_q + 3'd1;
            if (bitn_q == 3'd7) state_d = STOP;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        STOP: begin
          if (cnt_q == CntLast) begin
            cnt_d = '0;
            if (bit_f) begin
              data_d  = shreg_q;
              rdy_d   = 1'b1;
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = WAIT;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        WAIT: begin
          if (bit_f) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Idle flag is held rather than derived from the counter so it can reset high with the counter at 0.
  always_comb begin
    gap_d  = gap_q;
    idle_d = idle_q;
    if (state_q != IDLE || !bit_f) begin
      gap_d  = '0;
      idle_d = 1'b0;
    end else begin
      if (tick && gap_q != GapMax) gap_d = gap_q + GapW'(1);
      if (gap_q == GapMax) idle_d = 1'b1;
    end
  end

  assign eop        = idle_q & ~idle_prev_q & got_byte_q;
  assign got_byte_d = (got_byte_q & ~eop) | rdy_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= 2'b11;
      filt_q      <= 3'b111;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bitn_q      <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      rdy_q       <= 1'b0;
      ferr_q      <= 1'b0;
      gap_q       <= '0;
      idle_q      <= 1'b1;
      idle_prev_q <= 1'b1;
      got_byte_q  <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], bus.RxD};
      if (tick) filt_q <= {filt_q[1:0], sync_q[1]};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitn_q      <= bitn_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      rdy_q       <= rdy_d;
      ferr_q      <= ferr_d;
      gap_q       <= gap_d;
      idle_q      <= idle_d;
      idle_prev_q <= idle_q;
      got_byte_q  <= got_byte_d;
    end
  end

  assign bus.RxD_data          = data_q;
  assign bus.RxD_data_ready    = rdy_q;
  assign bus.RxD_framing_error = ferr_q;
  assign bus.RxD_idle          = idle_q;
  assign bus.RxD_endofpacket   = eop;

endmodule

// File: tb/tb_async_receiver.sv
// Bench for async_receiver: serial frames in, expected bytes/framing errors queued, monitor compares.
`timescale 1ns/1ps
module tb_async_receiver;

  localparam real BitNs = 1.0e9 / 115200.0;

  typedef struct packed {
    logic       ferr;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic rst;
  async_receiver_if bus();

  async_receiver dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         eop_cnt  = 0;
  int         exp_eop  = 0;
  bit         seg_good = 1'b0;
  logic [7:0] last_good = 8'h00;
  exp_t       exp_q[$];
  exp_t       e;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic expect_byte(input logic [7:0] b);
    exp_t t;
    t.ferr = 1'b0;
    t.data = b;
    exp_q.push_back(t);
    seg_good = 1'b1;
  endtask

  task automatic expect_ferr();
    exp_t t;
    t.ferr = 1'b1;
    t.data = 8'h00;
    exp_q.push_back(t);
  endtask

  task automatic send_byte(input logic [7:0] b, input real bit_ns, input logic stop);
    bus.RxD = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      bus.RxD = b[i];
      #(bit_ns);
    end
    bus.RxD = stop;
    #(bit_ns);
  endtask

  // An end-of-packet is owed after a long idle iff a good byte arrived since the previous idle.
  task automatic idle_check(input string name);
    bus.RxD = 1'b1;
    #(12.0 * BitNs);
    @(negedge clk);
    if (seg_good) exp_eop++;
    seg_good = 1'b0;
    chk({name, "_idle"}, int'(bus.RxD_idle), 1);
    chk({name, "_eop_count"}, eop_cnt, exp_eop);
    chk({name, "_all_received"}, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      last_good = 8'h00;
    end else begin
      if (bus.RxD_endofpacket) eop_cnt++;
      if (bus.RxD_data_ready || bus.RxD_framing_error) begin
        chk("ready_ferr_exclusive", int'(bus.RxD_data_ready & bus.RxD_framing_error), 0);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pulse: ready=%0b ferr=%0b data=%0h, expected no pulse",
                   bus.RxD_data_ready, bus.RxD_framing_error, bus.RxD_data);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind_ferr", int'(bus.RxD_framing_error), int'(e.ferr));
          if (e.ferr) begin
            chk("ferr_data_held", int'(bus.RxD_data), int'(last_good));
          end else begin
            chk("rx_data", int'(bus.RxD_data), int'(e.data));
            last_good = e.data;
          end
        end
      end
    end
  end

  initial begin
    #3_500_000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] c3;
    logic [7:0] rb;
    real        skew;
    c3      = 8'hC3;
    rst     = 1'b1;
    bus.RxD = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("reset_data", int'(bus.RxD_data), 0);
    chk("reset_ready", int'(bus.RxD_data_ready), 0);
    chk("reset_ferr", int'(bus.RxD_framing_error), 0);
    chk("reset_idle", int'(bus.RxD_idle), 1);
    chk("reset_eop", int'(bus.RxD_endofpacket), 0);
    rst = 1'b0;
    #(2.0 * BitNs);

    // Single frame; idle must drop once the frame is under way.
    expect_byte(8'h55);
    fork
      send_byte(8'h55, BitNs, 1'b1);
      begin
        #(3.0 * BitNs);
        @(negedge clk);
        chk("t1_idle_low_midframe", int'(bus.RxD_idle), 0);
      end
    join
    idle_check("t1");

    expect_byte(8'h00);
    expect_byte(8'hFF);
    expect_byte(8'hA5);
    send_byte(8'h00, BitNs, 1'b1);
    send_byte(8'hFF, BitNs, 1'b1);
    send_byte(8'hA5, BitNs, 1'b1);
    idle_check("t2");

    // 2 us glitch must be rejected and the receiver re-armed within one bit-time.
    bus.RxD = 1'b0;
    #2000;
    bus.RxD = 1'b1;
    #(BitNs - 2000.0);
    expect_byte(8'h5A);
    send_byte(8'h5A, BitNs, 1'b1);
    idle_check("t3");

    expect_ferr();
    send_byte(8'h3C, BitNs, 1'b0);
    #(3.0 * BitNs);
    bus.RxD = 1'b1;
    #(BitNs);
    expect_byte(8'h81);
    send_byte(8'h81, BitNs, 1'b1);
    idle_check("t4");

    // Reset mid-frame: partial 0xC3 must produce nothing.
    bus.RxD = 1'b0;
    #(BitNs);
    for (int i = 0; i < 4; i++) begin
      bus.RxD = c3[i];
      #(BitNs);
    end
    @(negedge clk);
    rst      = 1'b1;
    bus.RxD  = 1'b1;
    seg_good = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t5_rst_data", int'(bus.RxD_data), 0);
    chk("t5_rst_ready", int'(bus.RxD_data_ready), 0);
    chk("t5_rst_ferr", int'(bus.RxD_framing_error), 0);
    chk("t5_rst_idle", int'(bus.RxD_idle), 1);
    chk("t5_rst_eop", int'(bus.RxD_endofpacket), 0);
    rst = 1'b0;
    #(2.0 * BitNs);
    expect_byte(8'h81);
    send_byte(8'h81, BitNs, 1'b1);
    idle_check("t5");

    // Sender 3% fast, then a second long idle with no new byte.
    expect_byte(8'h12);
    send_byte(8'h12, BitNs / 1.03, 1'b1);
    idle_check("t6");
    #(12.0 * BitNs);
    @(negedge clk);
    chk("t6_no_second_eop", eop_cnt, exp_eop);
    chk("t6_still_idle", int'(bus.RxD_idle), 1);

    // Random bytes, random +/-2% skew, random inter-frame gaps.
    for (int k = 0; k < 5; k++) begin
      rb   = 8'($urandom);
      skew = 0.98 + real'($urandom_range(0, 40)) / 1000.0;
      expect_byte(rb);
      send_byte(rb, BitNs * skew, 1'b1);
      #(real'($urandom_range(0, 2)) * BitNs);
    end
    idle_check("t7");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
